leaf_router_param: RTL and testbench
====================================

Name: leaf_router_param

Overview:
- Parametrised successor of the fixed 4-spine leaf router.
- One local GPU/NI port plus NUM_SPINES spine ports, each with an input FIFO and real ready/valid backpressure; this replaces the "router always ready" tie-off.
- Routes single-flit packets by the destination address carried in the flit header.
- Each output uses a registered round-robin arbiter.
- Sits between the NI and the spine layer inside each GPU tile.

Parameters:
- DWIDTH, 16, flit width in bits.
- ADDR_W, 6, destination field width, taken from flit[DWIDTH-1:DWIDTH-ADDR_W]; dest = {group[ADDR_W-3:0], local[1:0]}.
- NUM_SPINES, 4, spine port count; power of two, 2..8.
- FIFO_DEPTH, 4, entries per input FIFO; power of two, at least 2.
- GROUP_ID, 4'h2, this leaf's group.
- LOCAL_ID, 2'd0, this router's local index.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- arb_enable  in  1  when 1, the arbiters may issue new grants.
- in_data  in  NP*DWIDTH  input flits, NP = NUM_SPINES+1; port 0 = GPU, port k = spine k-1.
- in_valid  in  NP  input valid.
- in_ready  out  NP  input ready (= FIFO not full).
- out_data  out  NP*DWIDTH  output flits.
- out_valid  out  NP  output valid.
- out_ready  in  NP  downstream ready.
- fifo_full  out  NP  per-input FIFO full.
- fifo_empty  out  NP  per-input FIFO empty.
- current_grant  out  NP*NP  one-hot grant per output for this cycle; row o = output o.
- flit_count  out  32  forwarded-flit counter (optional feature).
- drop_count  out  16  dropped-flit counter (optional feature).

Behaviour:
- Reset values:
  - All FIFOs empty; in_ready = all 1; fifo_empty = all 1; fifo_full = 0.
  - out_valid = 0; out_data = 0; current_grant = 0.
  - Round-robin pointers = 0; counters = 0.
- Reset mid-operation discards all buffered and held flits; nothing is replayed.
- Input push: occurs when in_valid[p] & in_ready[p]. A push and a pop on a full FIFO in the same cycle: the pop frees the slot next cycle, and in_ready stays 0 this cycle (no combinational ready path).
- Route of the head flit at input p, with dest from the header:
  - dest == {GROUP_ID, LOCAL_ID}: route to port 0. GPU-to-self loopback is allowed.
  - Otherwise, if p == 0: route to spine port 1 + dest[log2(NUM_SPINES)-1:0].
  - Otherwise (p != 0, non-local): misroute. The flit is popped without arbitration on the cycle it reaches the head and drop_count increments.
- Arbitration, per output o:
  - Candidates are inputs with a non-empty head routed to o.
  - A grant is issued when arb_enable = 1 and the output register is free: out_valid[o] = 0, or out_valid[o] & out_ready[o] this cycle.
  - Round-robin search starts at ptr[o]. After a grant to input i, ptr[o] = i+1 mod NP.
  - An input is routed to only one output, so two outputs never pop the same FIFO.
- Output register: on a grant, out_data[o] and out_valid[o] load at the next edge. Data and valid are held stable until accepted (out_ready = 1).
- Latency: a flit pushed at edge 0 can appear at an output after edge 2 (2 cycles) with no contention.
- Throughput: 1 flit/cycle per output when out_ready is held at 1.
- arb_enable = 0: no new grants. Held outputs still drain, FIFOs still accept until full, and misroute drops still occur.
- Widths: FIFO pointers are log2(FIFO_DEPTH)+1 bits, so wrap is distinguished from full.

Optional Feature:
- Macro ROUTER_STATS_EN.
- Defined:
  - flit_count increments by the number of output handshakes per cycle (0..NP); it wraps modulo 2^32.
  - drop_count increments per misroute drop and saturates at 16'hFFFF.
- Undefined: flit_count and drop_count are constant 0 and no counter logic is built; the misroute drop itself still happens.

Test Plan:
- Reset, then GPU in_data = 16'h2155 (dest 6'h08 = local) with out_ready = all 1 -> out_valid[0] = 1 with 16'h2155 exactly 2 cycles after the push; all other out_valid = 0.
- GPU in_data = 16'h34AA (dest 6'b001101) -> appears on port 2 (spine 1); flit_count = 1 with ROUTER_STATS_EN defined.
- Spine ports 1, 2 and 3 each send 3 flits to dest 6'h08 in the same cycle, out_ready[0] = 1 -> port 0 outputs them in order 1,2,3,1,2,3,1,2,3 over 9 consecutive cycles.
- out_ready[2] = 0, GPU pushes 6 flits to port 2 -> out_valid[2] holds the first flit, 4 flits buffered, in_ready[0] = 0 and fifo_full[0] = 1. Release out_ready -> all 5 remaining arrive in order, nothing lost, in_ready returns to 1.
- Spine port 3 sends 16'h34AA (non-local) -> no output valid; drop_count = 1 (stats on) or 0 (stats off).
- arb_enable = 0 with 2 flits queued -> no out_valid. Set arb_enable = 1 -> flits emerge 1 cycle later. Assert reset mid-stream -> the next cycle shows out_valid = 0 and fifo_empty = all 1.

Source files
------------

// File: rtl/leaf_router_param.sv
// Leaf router: GPU port plus NUM_SPINES spine ports, per-input FIFOs, round-robin output arbiters.
// Define ROUTER_STATS_EN to build the forwarded/dropped flit counters.
module leaf_router_param #(
    parameter int unsigned       DWIDTH     = 16,
    parameter int unsigned       ADDR_W     = 6,
    parameter int unsigned       NUM_SPINES = 4,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-3:0] GROUP_ID   = 'h2,
    parameter logic [1:0]        LOCAL_ID   = 2'd0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               arb_enable,
    input  logic [(NUM_SPINES+1)*DWIDTH-1:0]   in_data,
    input  logic [NUM_SPINES:0]                in_valid,
    output logic [NUM_SPINES:0]                in_ready,
    output logic [(NUM_SPINES+1)*DWIDTH-1:0]   out_data,
    output logic [NUM_SPINES:0]                out_valid,
    input  logic [NUM_SPINES:0]                out_ready,
    output logic [NUM_SPINES:0]                fifo_full,
    output logic [NUM_SPINES:0]                fifo_empty,
    output logic [(NUM_SPINES+1)**2-1:0]       current_grant,
    output logic [31:0]                        flit_count,
    output logic [15:0]                        drop_count
);

    localparam int unsigned NP = NUM_SPINES + 1;
    localparam int unsigned SW = $clog2(NUM_SPINES);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned GW = $clog2(NP);

    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] a, input int unsigned k);
        int unsigned s;
        s = 32'(a) + k;
        if (s >= NP) s = s - NP;
        return GW'(s);
    endfunction

    logic [DWIDTH-1:0] mem_q     [NP][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q  [NP];
    logic [PW-1:0]     rd_ptr_q  [NP];
    logic [PW-1:0]     vis_ptr_q [NP];
    logic [GW-1:0]     rr_ptr_q  [NP];
    logic [DWIDTH-1:0] out_data_q [NP];
    logic [NP-1:0]     out_valid_q;

    logic [NP-1:0]     full, empty, head_vld, push, pop, drop;
    logic [DWIDTH-1:0] head [NP];
    logic [ADDR_W-1:0] dest [NP];
    logic [NP-1:0]     req  [NP];
    logic [NP-1:0]     gnt  [NP];
    logic [GW-1:0]     gnt_idx [NP];
    logic              arb_hit;

    // Newly written entries only become visible to the arbiter one cycle later (vis_ptr_q).
    always_comb begin
        for (int o = 0; o < NP; o++) req[o] = '0;
        for (int p = 0; p < NP; p++) begin
            empty[p]    = (wr_ptr_q[p] == rd_ptr_q[p]);
            full[p]     = (wr_ptr_q[p][PW-1] != rd_ptr_q[p][PW-1]) &&
                          (wr_ptr_q[p][AW-1:0] == rd_ptr_q[p][AW-1:0]);
            head_vld[p] = (vis_ptr_q[p] != rd_ptr_q[p]);
            head[p]     = mem_q[p][rd_ptr_q[p][AW-1:0]];
            dest[p]     = head[p][DWIDTH-1 -: ADDR_W];
            push[p]     = in_valid[p] & ~full[p];
            drop[p]     = 1'b0;
            if (head_vld[p]) begin
                if (dest[p] == {GROUP_ID, LOCAL_ID}) begin
                    req[0][p] = 1'b1;
                end else if (p == 0) begin
                    req[GW'(1) + GW'(dest[p][SW-1:0])][0] = 1'b1;
                end else begin
                    drop[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        arb_hit = 1'b0;
        for (int o = 0; o < NP; o++) begin
            gnt[o]     = '0;
            gnt_idx[o] = '0;
            arb_hit    = 1'b0;
            if (arb_enable && !reset && (!out_valid_q[o] || out_ready[o])) begin
                for (int unsigned k = 0; k < NP; k++) begin
                    if (!arb_hit && req[o][wrap_add(rr_ptr_q[o], k)]) begin
                        arb_hit                           = 1'b1;
                        gnt_idx[o]                        = wrap_add(rr_ptr_q[o], k);
                        gnt[o][wrap_add(rr_ptr_q[o], k)]  = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        pop = drop;
        for (int o = 0; o < NP; o++) pop = pop | gnt[o];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                wr_ptr_q[p]   <= '0;
                rd_ptr_q[p]   <= '0;
                vis_ptr_q[p]  <= '0;
                rr_ptr_q[p]   <= '0;
                out_data_q[p] <= '0;
            end
            out_valid_q <= '0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (push[p]) begin
                    mem_q[p][wr_ptr_q[p][AW-1:0]] <= in_data[p*DWIDTH +: DWIDTH];
                    wr_ptr_q[p] <= wr_ptr_q[p] + PW'(1);
                end
                if (pop[p]) rd_ptr_q[p] <= rd_ptr_q[p] + PW'(1);
                vis_ptr_q[p] <= wr_ptr_q[p];
            end
            for (int o = 0; o < NP; o++) begin
                if (|gnt[o]) begin
                    out_valid_q[o] <= 1'b1;
                    out_data_q[o]  <= head[gnt_idx[o]];
                    rr_ptr_q[o]    <= wrap_add(gnt_idx[o], 1);
                end else if (out_ready[o]) begin
                    out_valid_q[o] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_data      = '0;
        current_grant = '0;
        for (int o = 0; o < NP; o++) begin
            out_data[o*DWIDTH +: DWIDTH] = out_data_q[o];
            current_grant[o*NP +: NP]    = gnt[o];
        end
    end

    assign out_valid  = out_valid_q;
    assign in_ready   = ~full;
    assign fifo_full  = full;
    assign fifo_empty = empty;

`ifdef ROUTER_STATS_EN
    localparam int unsigned CW = $clog2(NP + 1);
    logic [CW-1:0] hs_cnt, drop_cnt;
    logic [16:0]   drop_sum;
    logic [31:0]   flit_count_q;
    logic [15:0]   drop_count_q;

    always_comb begin
        hs_cnt   = '0;
        drop_cnt = '0;
        for (int o = 0; o < NP; o++) begin
            hs_cnt   = hs_cnt + CW'(out_valid_q[o] & out_ready[o]);
            drop_cnt = drop_cnt + CW'(drop[o]);
        end
        drop_sum = {1'b0, drop_count_q} + 17'(drop_cnt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            flit_count_q <= flit_count_q + 32'(hs_cnt);
            drop_count_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign flit_count = flit_count_q;
    assign drop_count = drop_count_q;
`else
    assign flit_count = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_leaf_router_param.sv
// Scoreboard bench for leaf_router_param: routing, latency, round-robin order, backpressure,
// misroute drops, arb_enable gating and mid-stream reset.
module tb_leaf_router_param;

    localparam int NP = 5;
    localparam int DW = 16;

    logic              clk, reset, arb_enable;
    logic [NP*DW-1:0]  in_data, out_data;
    logic [NP-1:0]     in_valid, in_ready, out_valid, out_ready, fifo_full, fifo_empty;
    logic [NP*NP-1:0]  current_grant;
    logic [31:0]       flit_count;
    logic [15:0]       drop_count;

    int          checks = 0;
    int          errors = 0;
    int          exp_drops = 0;
    logic [15:0] exp_q [NP][$];
    logic [15:0] exp_d;

    leaf_router_param dut (
        .clk           (clk),
        .reset         (reset),
        .arb_enable    (arb_enable),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .current_grant (current_grant),
        .flit_count    (flit_count),
        .drop_count    (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int route(input int p, input logic [15:0] d);
        logic [5:0] dst;
        dst = d[15:10];
        if (dst == 6'h08) return 0;
        if (p == 0) return 1 + int'(dst[1:0]);
        return -1;
    endfunction

    // Output monitor: every handshake must match the head of that port's expected queue.
    always @(negedge clk) begin
        if (!reset) begin
            for (int o = 0; o < NP; o++) begin
                if (out_valid[o] && out_ready[o]) begin
                    checks++;
                    if (exp_q[o].size() == 0) begin
                        errors++;
                        $display("FAIL sb_port%0d: got unexpected flit %h, required none", o,
                                 out_data[o*DW +: DW]);
                    end else begin
                        exp_d = exp_q[o].pop_front();
                        if (out_data[o*DW +: DW] !== exp_d) begin
                            errors++;
                            $display("FAIL sb_port%0d: got %h, required %h", o,
                                     out_data[o*DW +: DW], exp_d);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset      = 1'b1;
        in_valid   = '0;
        in_data    = '0;
        out_ready  = '1;
        arb_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int o = 0; o < NP; o++) exp_q[o].delete();
        exp_drops = 0;
    endtask

    task automatic push_flit(input int p, input logic [15:0] d);
        int budget;
        int r;
        budget = 50;
        in_data[p*DW +: DW] = d;
        in_valid[p] = 1'b1;
        @(negedge clk);
        while (!in_ready[p] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            checks++;
            errors++;
            $display("FAIL push_timeout port%0d: in_ready stayed 0, required 1", p);
        end
        @(posedge clk);
        #1;
        in_valid[p] = 1'b0;
        r = route(p, d);
        if (r >= 0) exp_q[r].push_back(d);
        else exp_drops++;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (in_ready !== 5'h1F) begin
            errors++; $display("FAIL rst_in_ready: got %b, required 11111", in_ready);
        end
        checks++;
        if (fifo_empty !== 5'h1F || fifo_full !== 5'h00) begin
            errors++; $display("FAIL rst_fifo: got empty %b full %b, required 11111 00000",
                               fifo_empty, fifo_full);
        end
        checks++;
        if (out_valid !== 5'h00 || out_data !== '0) begin
            errors++; $display("FAIL rst_out: got valid %b data %h, required 0", out_valid, out_data);
        end
        checks++;
        if (current_grant !== '0 || flit_count !== 32'd0 || drop_count !== 16'd0) begin
            errors++; $display("FAIL rst_grant_cnt: got grant %h flits %0d drops %0d, required 0",
                               current_grant, flit_count, drop_count);
        end
    endtask

    task automatic test_local_latency();
        do_reset();
        push_flit(0, 16'h2155);
        @(negedge clk);
        checks++;
        if (out_valid !== 5'h00) begin
            errors++; $display("FAIL lat_cycle1: got valid %b, required 00000", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 5'h00 || current_grant[NP-1:0] !== 5'b00001) begin
            errors++; $display("FAIL lat_cycle2: got valid %b grant0 %b, required 00000 00001",
                               out_valid, current_grant[NP-1:0]);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 5'b00001 || out_data[DW-1:0] !== 16'h2155) begin
            errors++; $display("FAIL lat_out: got valid %b data %h, required 00001 2155",
                               out_valid, out_data[DW-1:0]);
        end
    endtask

    task automatic test_spine_route();
        do_reset();
        push_flit(0, 16'h34AA);
        repeat (2) @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 5'b00100 || out_data[2*DW +: DW] !== 16'h34AA) begin
            errors++; $display("FAIL spine_out: got valid %b data %h, required 00100 34aa",
                               out_valid, out_data[2*DW +: DW]);
        end
        @(negedge clk);
        checks++;
`ifdef ROUTER_STATS_EN
        if (flit_count !== 32'd1) begin
            errors++; $display("FAIL flit_count: got %0d, required 1", flit_count);
        end
`else
        if (flit_count !== 32'd0) begin
            errors++; $display("FAIL flit_count: got %0d, required 0", flit_count);
        end
`endif
    endtask

    task automatic test_round_robin();
        int first_c, last_c, vcnt;
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int k = 1; k <= 3; k++) in_data[k*DW +: DW] = 16'h2100 | 16'(k << 4) | 16'(b);
            in_valid = 5'b01110;
            @(negedge clk);
            checks++;
            if (in_ready[3:1] !== 3'b111) begin
                errors++; $display("FAIL rr_ready: got %b, required 111", in_ready[3:1]);
            end
            @(posedge clk);
            #1;
            for (int k = 1; k <= 3; k++) exp_q[0].push_back(in_data[k*DW +: DW]);
        end
        in_valid = '0;
        first_c = -1; last_c = -1; vcnt = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                vcnt++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        checks++;
        if (vcnt != 9 || last_c - first_c != 8) begin
            errors++; $display("FAIL rr_burst: got %0d valid over span %0d, required 9 over 8",
                               vcnt, last_c - first_c);
        end
    endtask

    task automatic test_backpressure();
        int   idx;
        logic acc;
        do_reset();
        out_ready[2] = 1'b0;
        idx = 0;
        in_data[DW-1:0] = 16'h3400;
        in_valid[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = in_ready[0] && (idx < 6);
            @(posedge clk);
            #1;
            if (acc) begin exp_q[2].push_back(16'h3400 | 16'(idx)); idx++; end
            if (idx < 6) in_data[DW-1:0] = 16'h3400 | 16'(idx);
            else in_valid[0] = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (idx != 5) begin
            errors++; $display("FAIL bp_accepted: got %0d, required 5", idx);
        end
        checks++;
        if (out_valid[2] !== 1'b1 || out_data[2*DW +: DW] !== 16'h3400) begin
            errors++; $display("FAIL bp_hold: got valid %b data %h, required 1 3400",
                               out_valid[2], out_data[2*DW +: DW]);
        end
        checks++;
        if (in_ready[0] !== 1'b0 || fifo_full[0] !== 1'b1) begin
            errors++; $display("FAIL bp_full: got ready %b full %b, required 0 1",
                               in_ready[0], fifo_full[0]);
        end
        @(posedge clk);
        #1;
        out_ready[2] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            acc = in_ready[0] && (idx < 6);
            @(posedge clk);
            #1;
            if (acc) begin exp_q[2].push_back(16'h3400 | 16'(idx)); idx++; end
            if (idx < 6) in_data[DW-1:0] = 16'h3400 | 16'(idx);
            else in_valid[0] = 1'b0;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (idx != 6 || exp_q[2].size() != 0 || in_ready[0] !== 1'b1) begin
            errors++; $display("FAIL bp_drain: got pushed %0d pending %0d ready %b, required 6 0 1",
                               idx, exp_q[2].size(), in_ready[0]);
        end
    endtask

    task automatic test_misroute();
        int seen;
        do_reset();
        push_flit(3, 16'h34AA);
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid !== 5'h00) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL drop_noout: got %0d valid cycles, required 0", seen);
        end
        checks++;
`ifdef ROUTER_STATS_EN
        if (drop_count !== 16'(exp_drops) || fifo_empty !== 5'h1F) begin
            errors++; $display("FAIL drop_count: got %0d empty %b, required %0d 11111",
                               drop_count, fifo_empty, exp_drops);
        end
`else
        if (drop_count !== 16'd0 || fifo_empty !== 5'h1F) begin
            errors++; $display("FAIL drop_count: got %0d empty %b, required 0 11111",
                               drop_count, fifo_empty);
        end
`endif
    endtask

    task automatic test_arb_enable_and_reset();
        int seen;
        do_reset();
        arb_enable = 1'b0;
        push_flit(0, 16'h2155);
        push_flit(0, 16'h2156);
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid !== 5'h00) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL arb_off: got %0d valid cycles, required 0", seen);
        end
        @(posedge clk);
        #1;
        arb_enable = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 5'h00 || current_grant[NP-1:0] !== 5'b00001) begin
            errors++; $display("FAIL arb_on_grant: got valid %b grant0 %b, required 00000 00001",
                               out_valid, current_grant[NP-1:0]);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 5'b00001 || out_data[DW-1:0] !== 16'h2155) begin
            errors++; $display("FAIL arb_on_out: got valid %b data %h, required 00001 2155",
                               out_valid, out_data[DW-1:0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int o = 0; o < NP; o++) exp_q[o].delete();
        @(negedge clk);
        checks++;
        if (out_valid !== 5'h00 || fifo_empty !== 5'h1F) begin
            errors++; $display("FAIL mid_reset: got valid %b empty %b, required 00000 11111",
                               out_valid, fifo_empty);
        end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid !== 5'h00) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL no_replay: got %0d valid cycles, required 0", seen);
        end
    endtask

    initial begin
        reset      = 1'b1;
        arb_enable = 1'b1;
        in_valid   = '0;
        in_data    = '0;
        out_ready  = '1;
        test_reset();
        test_local_latency();
        test_spine_route();
        test_round_robin();
        test_backpressure();
        test_misroute();
        test_arb_enable_and_reset();
        repeat (3) @(negedge clk);
        for (int o = 0; o < NP; o++) begin
            checks++;
            if (exp_q[o].size() != 0) begin
                errors++; $display("FAIL final_pending port%0d: got %0d, required 0", o,
                                   exp_q[o].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
